// File: rtl/alu_exec.sv
// alu_exec: single-issue RV32I execute stage with a bit-serial shifter
module alu_exec (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] inst,
    input  logic [3:0]  alu_op,
    input  logic [31:0] imm,
    input  logic [4:0]  rd,
    input  logic        stall,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    output logic        out_valid,
    output logic [31:0] result,
    output logic [4:0]  rd_out,
    output logic        we,
    output logic        redirect,
    output logic [31:0] target,
    output logic        stall_release,
    output logic        busy
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;
    logic [0:0]  state;
    logic [4:0]  cnt;
    logic [31:0] sh_val, sh_next;
    logic        sh_left, sh_arith, p_we, p_stall;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        is_op, is_opi, is_br, is_jal, is_jalr, is_lui, is_auipc, is_load, is_store;
    logic [31:0] i_imm, s_imm, u_imm, j_imm, b, alu_y, res_c, tgt_c, jalr_t;
    logic        sub, take, we_c, redir_c, is_shift, start_shift;
    assign opc      = inst[6:0];
    assign f3       = alu_op[2:0];
    assign is_op    = opc == 7'b0110011;
    assign is_opi   = opc == 7'b0010011;
    assign is_br    = opc == 7'b1100011;
    assign is_jal   = opc == 7'b1101111;
    assign is_jalr  = opc == 7'b1100111;
    assign is_lui   = opc == 7'b0110111;
    assign is_auipc = opc == 7'b0010111;
    assign is_load  = opc == 7'b0000011;
    assign is_store = opc == 7'b0100011;
    assign i_imm    = {{20{inst[31]}}, inst[31:20]};
    assign s_imm    = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign u_imm    = {inst[31:12], 12'b0};
    assign j_imm    = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    assign b        = is_op ? rs2_val : is_store ? s_imm : i_imm;
    // ADDI carries inst[30] as immediate data, so only register ops may subtract
    assign sub      = is_op & alu_op[3];
    assign is_shift = (is_op | is_opi) & (f3 == 3'b001 | f3 == 3'b101);
    assign start_shift = is_shift & (b[4:0] != 5'd0);
    assign jalr_t   = rs1_val + i_imm;
    assign sh_next  = sh_left ? {sh_val[30:0], 1'b0} : {sh_arith & sh_val[31], sh_val[31:1]};
    assign busy     = state == SHIFT;
    assign in_ready = ~busy;
    always_comb begin
        case (f3)
            3'b000:  alu_y = sub ? rs1_val - b : rs1_val + b;
            3'b010:  alu_y = {31'b0, $signed(rs1_val) < $signed(b)};
            3'b011:  alu_y = {31'b0, rs1_val < b};
            3'b100:  alu_y = rs1_val ^ b;
            3'b110:  alu_y = rs1_val | b;
            3'b111:  alu_y = rs1_val & b;
            default: alu_y = rs1_val;
        endcase
        case (inst[14:12])
            3'b000:  take = rs1_val == rs2_val;
            3'b001:  take = rs1_val != rs2_val;
            3'b100:  take = $signed(rs1_val) < $signed(rs2_val);
            3'b101:  take = $signed(rs1_val) >= $signed(rs2_val);
            3'b110:  take = rs1_val < rs2_val;
            3'b111:  take = rs1_val >= rs2_val;
            default: take = 1'b0;
        endcase
        res_c   = (is_op | is_opi) ? alu_y :
                  (is_jal | is_jalr) ? pc + 32'd4 :
                  is_lui ? u_imm :
                  is_auipc ? pc + u_imm :
                  (is_load | is_store) ? rs1_val + b : 32'd0;
        tgt_c   = is_br ? pc + imm : is_jal ? pc + j_imm : {jalr_t[31:1], 1'b0};
        redir_c = (is_br & take) | is_jal | is_jalr;
        we_c    = (rd != 5'd0) & (is_op | is_opi | is_jal | is_jalr | is_lui | is_auipc);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= 5'd0;
            sh_val        <= 32'd0;
            sh_left       <= 1'b0;
            sh_arith      <= 1'b0;
            p_we          <= 1'b0;
            p_stall       <= 1'b0;
            out_valid     <= 1'b0;
            result        <= 32'd0;
            rd_out        <= 5'd0;
            we            <= 1'b0;
            redirect      <= 1'b0;
            target        <= 32'd0;
            stall_release <= 1'b0;
        end else begin
            out_valid     <= 1'b0;
            we            <= 1'b0;
            redirect      <= 1'b0;
            stall_release <= 1'b0;
            if (state == SHIFT) begin
                sh_val <= sh_next;
                cnt    <= cnt - 5'd1;
                if (cnt == 5'd1) begin
                    state         <= IDLE;
                    out_valid     <= 1'b1;
                    result        <= sh_next;
                    we            <= p_we;
                    stall_release <= p_stall;
                end
            end else if (in_valid) begin
                rd_out <= rd;
                if (start_shift) begin
                    state    <= SHIFT;
                    cnt      <= b[4:0];
                    sh_val   <= rs1_val;
                    sh_left  <= f3 == 3'b001;
                    sh_arith <= alu_op[3];
                    p_we     <= we_c;
                    p_stall  <= stall;
                end else begin
                    out_valid     <= 1'b1;
                    result        <= res_c;
                    we            <= we_c;
                    redirect      <= redir_c;
                    target        <= tgt_c;
                    stall_release <= stall;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed vectors with a queue scoreboard for alu_exec
module tb_alu_exec;
    logic        clock = 1'b0, reset = 1'b1, in_valid = 1'b0, stall = 1'b0;
    logic [31:0] inst = 32'd0, imm = 32'd0, pc = 32'd0, rs1_val = 32'd0, rs2_val = 32'd0;
    logic [3:0]  alu_op = 4'd0;
    logic [4:0]  rd = 5'd0;
    logic        in_ready, out_valid, we, redirect, stall_release, busy;
    logic [31:0] result, target;
    logic [4:0]  rd_out;
    int total = 0, bad = 0;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        we, redir;
        logic [31:0] tgt;
        logic        srel, chk_res;
    } exp_t;
    exp_t sb[$];

    alu_exec dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .inst(inst), .alu_op(alu_op), .imm(imm), .rd(rd), .stall(stall), .pc(pc),
        .rs1_val(rs1_val), .rs2_val(rs2_val), .out_valid(out_valid), .result(result),
        .rd_out(rd_out), .we(we), .redirect(redirect), .target(target),
        .stall_release(stall_release), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(logic [31:0] r, logic [4:0] d, logic w, logic rdr,
                                logic [31:0] t, logic s, logic c);
        exp_t e;
        e.res = r; e.rd = d; e.we = w; e.redir = rdr; e.tgt = t; e.srel = s; e.chk_res = c;
        return e;
    endfunction

    function automatic logic [31:0] r_ty(logic [6:0] f7, logic [2:0] f, logic [4:0] d, logic [6:0] o);
        return {f7, 10'b0, f, d, o};
    endfunction

    function automatic logic [31:0] i_ty(logic [11:0] im, logic [2:0] f, logic [4:0] d, logic [6:0] o);
        return {im, 5'b0, f, d, o};
    endfunction

    function automatic logic [3:0] aop(logic [31:0] i);
        return (i[6:0] == 7'h33 || i[6:0] == 7'h13) ? {i[30], i[14:12]} : 4'h0;
    endfunction

    // Scoreboard monitor: every out_valid pulse must match the oldest expectation
    always @(negedge clock) begin
        if (!reset && out_valid) begin
            if (sb.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk_res) chk("result", result, e.res);
                chk("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
                chk("we", {31'd0, we}, {31'd0, e.we});
                chk("redirect", {31'd0, redirect}, {31'd0, e.redir});
                if (e.redir) chk("target", target, e.tgt);
                chk("stall_release", {31'd0, stall_release}, {31'd0, e.srel});
            end
        end
    end

    task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] bv,
                         input logic [31:0] im, input logic [31:0] p, input logic [4:0] d,
                         input logic st, input int nsh, input bit poke, input exp_t e);
        int n = 0;
        int busy_n = 0;
        @(negedge clock);
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        inst = ins; alu_op = aop(ins); rs1_val = a; rs2_val = bv; imm = im; pc = p;
        rd = d; stall = st; in_valid = 1'b1;
        sb.push_back(e);
        @(posedge clock);
        #1;
        if (poke) inst = r_ty(7'h00, 3'd0, 5'd1, 7'h33);
        else in_valid = 1'b0;
        for (int k = 1; k <= nsh + 1; k++) begin
            @(negedge clock);
            if (k == nsh && poke) in_valid = 1'b0;
            if (k <= nsh) busy_n += int'(busy);
        end
        chk("busy_cycles", busy_n, nsh);
        chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_result", result, 32'd0);
        chk("rst_target", target, 32'd0);
        chk("rst_rd_out", {27'd0, rd_out}, 32'd0);
        chk("rst_flags", {28'd0, we, redirect, stall_release, out_valid}, 32'd0);
        reset = 1'b0;

        issue(r_ty(7'h00, 3'd0, 5'd3, 7'h33), 32'd5, 32'd7, 32'd0, 32'd0, 5'd3, 1'b0, 0, 0,
              mk(32'd12, 5'd3, 1, 0, 0, 0, 1));
        issue(r_ty(7'h20, 3'd0, 5'd4, 7'h33), 32'd5, 32'd7, 32'd0, 32'd0, 5'd4, 1'b0, 0, 0,
              mk(32'hFFFFFFFE, 5'd4, 1, 0, 0, 0, 1));
        issue(r_ty(7'h00, 3'd2, 5'd5, 7'h33), 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 5'd5, 1'b0, 0, 0,
              mk(32'd1, 5'd5, 1, 0, 0, 0, 1));
        issue(r_ty(7'h00, 3'd3, 5'd5, 7'h33), 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 5'd5, 1'b0, 0, 0,
              mk(32'd0, 5'd5, 1, 0, 0, 0, 1));
        issue(r_ty(7'h00, 3'd7, 5'd6, 7'h33), 32'h0000F0F0, 32'h0000FF00, 32'd0, 32'd0, 5'd6, 1'b0, 0, 0,
              mk(32'h0000F000, 5'd6, 1, 0, 0, 0, 1));
        issue(i_ty(12'hFFF, 3'd0, 5'd7, 7'h13), 32'd10, 32'd0, 32'd0, 32'd0, 5'd7, 1'b0, 0, 0,
              mk(32'd9, 5'd7, 1, 0, 0, 0, 1));
        issue(r_ty(7'h20, 3'd5, 5'd8, 7'h33), 32'h80000000, 32'd4, 32'd0, 32'd0, 5'd8, 1'b0, 4, 1,
              mk(32'hF8000000, 5'd8, 1, 0, 0, 0, 1));
        issue(i_ty(12'h000, 3'd5, 5'd9, 7'h13), 32'h00001234, 32'd0, 32'd0, 32'd0, 5'd9, 1'b0, 0, 0,
              mk(32'h00001234, 5'd9, 1, 0, 0, 0, 1));
        issue(i_ty(12'h001, 3'd1, 5'd9, 7'h13), 32'd3, 32'd0, 32'd0, 32'd0, 5'd9, 1'b0, 1, 0,
              mk(32'd6, 5'd9, 1, 0, 0, 0, 1));
        issue(i_ty(12'h003, 3'd5, 5'd9, 7'h13), 32'h80000010, 32'd0, 32'd0, 32'd0, 5'd9, 1'b0, 3, 0,
              mk(32'h10000002, 5'd9, 1, 0, 0, 0, 1));
        issue(i_ty(12'h000, 3'd4, 5'd0, 7'h63), 32'hFFFFFFFF, 32'd1, 32'hFFFFFFF8, 32'h100, 5'd0, 1'b1, 0, 0,
              mk(32'd0, 5'd0, 0, 1, 32'h000000F8, 1, 0));
        issue(i_ty(12'h000, 3'd0, 5'd0, 7'h63), 32'd1, 32'd2, 32'h10, 32'h300, 5'd0, 1'b1, 0, 0,
              mk(32'd0, 5'd0, 0, 0, 0, 1, 0));
        issue(i_ty(12'h000, 3'd2, 5'd0, 7'h63), 32'd0, 32'd0, 32'h10, 32'h300, 5'd0, 1'b0, 0, 0,
              mk(32'd0, 5'd0, 0, 0, 0, 0, 0));
        issue(i_ty(12'h000, 3'd7, 5'd0, 7'h63), 32'hFFFFFFFF, 32'd1, 32'h20, 32'h400, 5'd0, 1'b0, 0, 0,
              mk(32'd0, 5'd0, 0, 1, 32'h420, 0, 0));
        issue(32'h008000EF, 32'd0, 32'd0, 32'd0, 32'h200, 5'd1, 1'b1, 0, 0,
              mk(32'h204, 5'd1, 1, 1, 32'h208, 1, 1));
        issue(i_ty(12'h004, 3'd0, 5'd1, 7'h67), 32'h1001, 32'd0, 32'd0, 32'h40, 5'd1, 1'b0, 0, 0,
              mk(32'h44, 5'd1, 1, 1, 32'h1004, 0, 1));
        issue(32'h123452B7, 32'd0, 32'd0, 32'd0, 32'd0, 5'd5, 1'b0, 0, 0,
              mk(32'h12345000, 5'd5, 1, 0, 0, 0, 1));
        issue(32'h00001317, 32'd0, 32'd0, 32'd0, 32'h1000, 5'd6, 1'b0, 0, 0,
              mk(32'h2000, 5'd6, 1, 0, 0, 0, 1));
        issue(i_ty(12'hFFC, 3'd2, 5'd7, 7'h03), 32'h100, 32'd0, 32'd0, 32'd0, 5'd7, 1'b0, 0, 0,
              mk(32'hFC, 5'd7, 0, 0, 0, 0, 1));
        issue(32'h00002423, 32'h100, 32'd5, 32'd0, 32'd0, 5'd8, 1'b0, 0, 0,
              mk(32'h108, 5'd8, 0, 0, 0, 0, 1));
        issue(32'h0000000F, 32'd3, 32'd4, 32'd0, 32'd0, 5'd9, 1'b0, 0, 0,
              mk(32'd0, 5'd9, 0, 0, 0, 0, 1));
        issue(r_ty(7'h00, 3'd0, 5'd0, 7'h33), 32'd1, 32'd1, 32'd0, 32'd0, 5'd0, 1'b0, 0, 0,
              mk(32'd2, 5'd0, 0, 0, 0, 0, 1));

        // Abort an SLL by 20 with reset in its second cycle: no result may ever appear
        @(negedge clock);
        inst = i_ty(12'd20, 3'd1, 5'd2, 7'h13); alu_op = aop(inst); rs1_val = 32'd1;
        rd = 5'd2; stall = 1'b0; in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        @(negedge clock);
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (25) @(negedge clock);
        issue(r_ty(7'h00, 3'd0, 5'd3, 7'h33), 32'd5, 32'd7, 32'd0, 32'd0, 5'd3, 1'b0, 0, 0,
              mk(32'd12, 5'd3, 1, 0, 0, 0, 1));

        repeat (3) @(negedge clock);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
